// File: rtl/virtio_pkg.sv
// Shared types and constants for the virtio memory-side blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package virtio_pkg;

    // virtio_mem_bridge transaction sequencer states
    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } mem_bridge_state_t;

    localparam logic       MEM_MODE_READ    = 1'b0;
    localparam logic       MEM_MODE_WRITE   = 1'b1;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/virtio_mem_bridge.sv
// Bridges virtio's single-outstanding pulse memory port to an AXI4-Lite master.
// Latency: request at N, completion pulse at N+3 with a zero-wait slave; +1 per wait cycle.
// Backpressure: none upstream; pulses arriving while busy are dropped and flagged sticky in mem_overrun.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   mem_request_enable/mode/addr/wdata/wstrb   request pulse and payload from virtio
//   mem_response_enable/data/error completion pulse, read data (0 for writes), non-OKAY flag
//   mem_busy, mem_overrun          transaction in flight, sticky dropped-request flag
//   axi_ar*/r*/aw*/w*/b*           AXI4-Lite master channels
module virtio_mem_bridge
    import virtio_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  mem_request_enable,
    input  logic                  mem_mode,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_response_enable,
    output logic [31:0]           mem_data,
    output logic                  mem_busy,
    output logic                  mem_error,
    output logic                  mem_overrun,

    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [2:0]            axi_arprot,
    input  logic [31:0]           axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,

    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [2:0]            axi_awprot,
    output logic [31:0]           axi_wdata,
    output logic [3:0]            axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready
);

    mem_bridge_state_t     state, state_n;
    logic                  aw_done, aw_done_n;
    logic                  w_done, w_done_n;
    logic [ADDR_WIDTH-1:0] addr_in, addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           data_q;
    logic                  err_q;
    logic                  overrun_q;
    logic                  accept;

    // Fit the 32-bit byte address to the AXI address width.
    generate
        if (ADDR_WIDTH > 32) begin : g_addr_ext
            assign addr_in = {{(ADDR_WIDTH-32){1'b0}}, mem_addr};
        end else if (ADDR_WIDTH == 32) begin : g_addr_eq
            assign addr_in = mem_addr;
        end else begin : g_addr_trunc
            assign addr_in = mem_addr[ADDR_WIDTH-1:0];
        end
    endgenerate

    assign accept = mem_request_enable && (state == IDLE);

    // Every valid/ready is a decode of flops only, so no AXI input reaches an AXI output.
    assign axi_araddr          = addr_q;
    assign axi_awaddr          = addr_q;
    assign axi_wdata           = wdata_q;
    assign axi_wstrb           = wstrb_q;
    assign axi_arprot          = AXI_PROT_DEFAULT;
    assign axi_awprot          = AXI_PROT_DEFAULT;
    assign axi_arvalid         = (state == RD_ADDR);
    assign axi_rready          = (state == RD_DATA);
    assign axi_awvalid         = (state == WR_REQ) && !aw_done;
    assign axi_wvalid          = (state == WR_REQ) && !w_done;
    assign axi_bready          = (state == WR_RESP);
    assign mem_response_enable = (state == DONE);
    assign mem_busy            = (state != IDLE);
    assign mem_data            = data_q;
    assign mem_error           = err_q;
    assign mem_overrun         = overrun_q;

    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (state)
            IDLE: begin
                if (mem_request_enable) begin
                    state_n   = (mem_mode == MEM_MODE_WRITE) ? WR_REQ : RD_ADDR;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            RD_ADDR: if (axi_arready) state_n = RD_DATA;
            RD_DATA: if (axi_rvalid)  state_n = DONE;
            WR_REQ: begin
                // AW and W complete independently; move on once both have handshaken.
                aw_done_n = aw_done || (axi_awvalid && axi_awready);
                w_done_n  = w_done  || (axi_wvalid  && axi_wready);
                if (aw_done_n && w_done_n) state_n = WR_RESP;
            end
            WR_RESP: if (axi_bvalid) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            if (accept) begin
                addr_q  <= addr_in;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            if (mem_request_enable && (state != IDLE)) begin
                overrun_q <= 1'b1;
            end
            // Error flag lives only in DONE so it coincides with the response pulse.
            err_q <= 1'b0;
            if ((state == RD_DATA) && axi_rvalid) begin
                data_q <= axi_rdata;
                err_q  <= (axi_rresp != AXI_RESP_OKAY);
            end
            if ((state == WR_RESP) && axi_bvalid) begin
                data_q <= '0;
                err_q  <= (axi_bresp != AXI_RESP_OKAY);
            end
        end
    end

endmodule
